// File: rtl/dma_copy_ctrl.sv
// Word-granular memory-to-memory copy engine driving the shared dmem port.
// Each word is a read/write pair; the port is released for one cycle every BURST words.
module dma_copy_ctrl #(
    parameter int LEN_W = 16,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cfg_src,
    input  logic [31:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             irq,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_write_data,
    output logic [1:0]       dmem_size,
    output logic             dmem_read_en,
    output logic             dmem_write_en,
    input  logic [31:0]      dmem_read_data,
    input  logic             mem_fault
);

    localparam int BW = $clog2(BURST + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, RD, RDW, WR, WRW, REL, FIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       src_q, src_d;
    logic [31:0]       dst_q, dst_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;
    logic              bus_req_q, bus_req_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              go_fin, go_err;

    // Outputs are computed from the next state so every strobe and address is a flop
    // that is valid in exactly the cycle the FSM sits in the matching state.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        burst_d = burst_q;
        data_d  = data_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        irq_d   = 1'b0;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        go_fin  = 1'b0;
        go_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_src[1:0] != 2'b00 || cfg_dst[1:0] != 2'b00 || cfg_len == '0) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                        irq_d  = 1'b1;
                    end else begin
                        src_d   = cfg_src;
                        dst_d   = cfg_dst;
                        count_d = cfg_len;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    burst_d = '0;
                    rd_en_d = 1'b1;
                    addr_d  = src_q;
                    state_d = RD;
                end
            end
            RD: state_d = RDW;
            RDW: begin
                data_d = dmem_read_data;
                if (mem_fault) begin
                    go_fin = 1'b1;
                    go_err = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                    addr_d  = dst_q;
                    state_d = WR;
                end
            end
            WR: begin
                src_d   = src_q + 32'd4;
                dst_d   = dst_q + 32'd4;
                count_d = count_q - LEN_W'(1);
                burst_d = burst_q + BW'(1);
                state_d = WRW;
            end
            WRW: begin
                if (mem_fault) begin
                    go_fin = 1'b1;
                    go_err = 1'b1;
                end else if (count_q == '0) begin
                    go_fin = 1'b1;
                end else if (burst_q == BW'(BURST)) begin
                    state_d = REL;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = src_q;
                    state_d = RD;
                end
            end
            REL: state_d = REQ;
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go_fin) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            irq_d   = 1'b1;
            err_d   = go_err;
        end

        bus_req_d = (state_d == REQ) || (state_d == RD) || (state_d == RDW) ||
                    (state_d == WR)  || (state_d == WRW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            burst_q   <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            bus_req_q <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            count_q   <= count_d;
            burst_q   <= burst_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            bus_req_q <= bus_req_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign irq             = irq_q;
    assign bus_req         = bus_req_q;
    assign dmem_addr       = addr_q;
    assign dmem_write_data = data_q;
    assign dmem_size       = 2'b10;
    assign dmem_read_en    = rd_en_q;
    assign dmem_write_en   = wr_en_q;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Directed bench for dma_copy_ctrl: word memory + fault window + delayed-grant arbiter,
// a table of transfers with hand-computed cycle/strobe counts, and corner sequences.
module tb_dma_copy_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_src = '0;
    logic [31:0] cfg_dst = '0;
    logic [15:0] cfg_len = '0;
    logic        cfg_start = 1'b0;
    logic        busy, done, err, irq, bus_req, bus_gnt;
    logic [31:0] dmem_addr, dmem_write_data;
    logic [1:0]  dmem_size;
    logic        dmem_read_en, dmem_write_en;
    logic [31:0] rdata = '0;
    logic        fault_q = 1'b0;

    dma_copy_ctrl #(.LEN_W(16), .BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_start(cfg_start),
        .busy(busy), .done(done), .err(err), .irq(irq),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data), .dmem_size(dmem_size),
        .dmem_read_en(dmem_read_en), .dmem_write_en(dmem_write_en),
        .dmem_read_data(rdata), .mem_fault(fault_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        logic [15:0] k;
        k = i[15:0];
        return {k ^ 16'hA5C3, ~k};
    endfunction

    // Memory: 1024 words at 0x000..0xFFC; any access at or above fault_lim faults.
    logic [31:0] mem [0:1023];
    logic        mem_init = 1'b0;
    logic [31:0] fault_lim = 32'h1000;
    int          gnt_delay = 0;
    int          wcnt = 0;

    always @(posedge clk) begin
        if (mem_init)
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        rdata   <= (dmem_read_en && dmem_addr < 32'h1000) ? mem[dmem_addr[11:2]] : 32'h0;
        fault_q <= (dmem_read_en || dmem_write_en) && (dmem_addr >= fault_lim);
        if (dmem_write_en && dmem_addr < 32'h1000 && !mem_init)
            mem[dmem_addr[11:2]] <= dmem_write_data;
        if (!bus_req) wcnt <= 0;
        else if (wcnt < gnt_delay) wcnt <= wcnt + 1;
    end

    assign bus_gnt = bus_req && (wcnt >= gnt_delay);

    int rd_tot = 0, wr_tot = 0, irq_tot = 0, rise_tot = 0, excl_bad = 0, nognt_bad = 0, size_bad = 0;
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        rd_tot  <= rd_tot + int'(dmem_read_en);
        wr_tot  <= wr_tot + int'(dmem_write_en);
        irq_tot <= irq_tot + int'(irq);
        if (bus_req && !req_prev) rise_tot <= rise_tot + 1;
        if (dmem_read_en && dmem_write_en) excl_bad <= excl_bad + 1;
        if ((dmem_read_en || dmem_write_en) && !bus_gnt) nognt_bad <= nognt_bad + 1;
        if (dmem_size != 2'b10) size_bad <= size_bad + 1;
        req_prev <= bus_req;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int copied(input logic [31:0] s, input logic [31:0] d, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) begin
            int si = int'(s >> 2) + k;
            int di = int'(d >> 2) + k;
            if (si < 1024 && di < 1024 && mem[di] === pat(si)) c++;
        end
        return c;
    endfunction

    task automatic init_mem();
        @(negedge clk) mem_init = 1'b1;
        @(negedge clk) mem_init = 1'b0;
    endtask

    // Returns at the first negedge after the edge that sampled cfg_start.
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        cfg_src = s; cfg_dst = d; cfg_len = n; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Edges after the start edge until done is seen (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 400) begin
            @(negedge clk);
            edges++;
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          gdly;
        logic        exp_err;
        int          exp_cyc;   // cycles from the start cycle through the FIN cycle
        int          exp_rd;
        int          exp_wr;
        int          exp_gnt;
        int          exp_copy;
    } vec_t;

    vec_t vecs [8];

    task automatic run_row(input int idx, input vec_t v);
        int e, r0, w0, i0, g0;
        gnt_delay = v.gdly;
        init_mem();
        r0 = rd_tot; w0 = wr_tot; i0 = irq_tot; g0 = rise_tot;
        start_xfer(v.src, v.dst, v.len[15:0]);
        wait_done(e);
        check($sformatf("row%0d_cycles", idx), 64'(e + 2), 64'(v.exp_cyc));
        check($sformatf("row%0d_err", idx), 64'(err), 64'(v.exp_err));
        check($sformatf("row%0d_irq_busy_req_at_done", idx), {61'd0, irq, busy, bus_req}, 64'b100);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("row%0d_reads", idx), 64'(rd_tot - r0), 64'(v.exp_rd));
        check($sformatf("row%0d_writes", idx), 64'(wr_tot - w0), 64'(v.exp_wr));
        check($sformatf("row%0d_irqs", idx), 64'(irq_tot - i0), 64'd1);
        check($sformatf("row%0d_grants", idx), 64'(rise_tot - g0), 64'(v.exp_gnt));
        check($sformatf("row%0d_copied", idx), 64'(copied(v.src, v.dst, v.len)), 64'(v.exp_copy));
        check($sformatf("row%0d_done_sticky", idx), 64'(done), 64'd1);
        gnt_delay = 0;
    endtask

    task automatic do_reject(input string nm, input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] n);
        int g0 = rise_tot;
        start_xfer(s, d, n);
        check({nm, "_status"}, {60'd0, err, done, irq, busy}, 64'b1110);
        repeat (4) @(negedge clk);
        check({nm, "_irq_cleared"}, 64'(irq), 64'd0);
        check({nm, "_no_bus_req"}, 64'(rise_tot - g0), 64'd0);
    endtask

    initial begin
        int e;
        // src, dst, len, gnt delay, err, cycles, reads, writes, grants, words copied
        vecs[0] = '{32'h100, 32'h200,  3,  0, 1'b0, 15,  3,  3, 1, 3};
        vecs[1] = '{32'h400, 32'h600, 10,  0, 1'b0, 47, 10, 10, 3, 10};
        vecs[2] = '{32'h100, 32'h800,  4, 20, 1'b0, 39,  4,  4, 1, 4};
        vecs[3] = '{32'h140, 32'h700,  5,  0, 1'b0, 25,  5,  5, 2, 5};
        vecs[4] = '{32'h010, 32'h020,  1,  0, 1'b0,  7,  1,  1, 1, 1};
        vecs[5] = '{32'h100, 32'h1000, 3,  0, 1'b1,  7,  1,  1, 1, 0};
        vecs[6] = '{32'h1000, 32'h200, 2,  0, 1'b1,  5,  1,  0, 1, 0};
        vecs[7] = '{32'h100, 32'hFFC,  2,  0, 1'b1, 11,  2,  2, 1, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {busy, done, err, irq, bus_req, dmem_read_en, dmem_write_en},
              64'd0);
        check("reset_addr_wdata", {dmem_addr, dmem_write_data}, 64'd0);

        for (int i = 0; i < 8; i++) run_row(i, vecs[i]);

        do_reject("reject_src", 32'h102, 32'h200, 16'd3);
        do_reject("reject_dst", 32'h100, 32'h201, 16'd3);
        do_reject("reject_len0", 32'h100, 32'h200, 16'd0);

        // Start pulse while busy must not disturb the running copy.
        init_mem();
        start_xfer(32'h100, 32'h200, 16'd3);
        repeat (3) @(negedge clk);
        cfg_src = 32'h102; cfg_len = 16'd0; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("busy_start_status", {61'd0, busy, done, err}, 64'b100);
        wait_done(e);
        check("busy_start_err", 64'(err), 64'd0);
        check("busy_start_copied", 64'(copied(32'h100, 32'h200, 3)), 64'd3);

        // Start in the FIN cycle is ignored; start in the following IDLE cycle is accepted.
        init_mem();
        start_xfer(32'h010, 32'h020, 16'd1);
        wait_done(e);
        cfg_src = 32'h010; cfg_dst = 32'h020; cfg_len = 16'd0; cfg_start = 1'b1;
        @(negedge clk);
        check("fin_start_ignored", {62'd0, done, err}, 64'b10);
        cfg_src = 32'h100; cfg_dst = 32'h400; cfg_len = 16'd2;
        @(negedge clk);
        cfg_start = 1'b0;
        check("post_fin_start_accepted", {62'd0, busy, done}, 64'b10);
        wait_done(e);
        check("post_fin_err", 64'(err), 64'd0);
        check("post_fin_copied", 64'(copied(32'h100, 32'h400, 2)), 64'd2);

        // Reset during word 2 (its RDW cycle) of a 5-word copy.
        init_mem();
        start_xfer(32'h100, 32'h200, 16'd5);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {busy, done, err, irq, bus_req, dmem_read_en, dmem_write_en},
              64'd0);
        check("midrst_addr_wdata", {dmem_addr, dmem_write_data}, 64'd0);
        rst = 1'b0;
        check("midrst_word1_kept", 64'(mem[32'h200 >> 2]), 64'(pat(32'h100 >> 2)));
        check("midrst_word2_untouched", 64'(mem[(32'h200 >> 2) + 1]), 64'(pat((32'h200 >> 2) + 1)));
        start_xfer(32'h100, 32'h300, 16'd5);
        wait_done(e);
        check("midrst_restart_cycles", 64'(e + 2), 64'd25);
        check("midrst_restart_err", 64'(err), 64'd0);
        check("midrst_restart_copied", 64'(copied(32'h100, 32'h300, 5)), 64'd5);

        @(negedge clk);
        check("strobe_exclusive", 64'(excl_bad), 64'd0);
        check("strobe_without_grant", 64'(nognt_bad), 64'd0);
        check("dmem_size_word", 64'(size_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
